tank_motion_ctl: RTL and testbench

//  Converts 10-bit joystick samples from the joystick SPI reader into a tank screen position.
//  It also produces a facing direction for the tank sprite generator.
//  The position is updated once per video frame and clamped to the 1024x768 visible area.

---
 rtl/tank_pkg.sv | 43 ++++
 rtl/tank_motion_ctl_shaper.sv | 30 +++
 rtl/tank_motion_ctl.sv | 142 ++++++++++++++
 tb/tb_tank_motion_ctl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tank_pkg : shared geometry, motion constants, direction codes, FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package tank_pkg;

  localparam int H_RES       = 1024;
  localparam int V_RES       = 768;
  localparam int TANK_W      = 64;
  localparam int TANK_H      = 64;
  localparam int X_MAX       = H_RES - TANK_W;
  localparam int Y_MAX       = V_RES - TANK_H;
  localparam int X_INIT      = 480;
  localparam int Y_INIT      = 352;
  localparam int CENTER      = 512;
  localparam int DEADZONE    = 64;
  localparam int FAST_THRESH = 320;
  localparam int STEP_SLOW   = 1;
  localparam int STEP_FAST   = 3;
  localparam int STABLE_CYC  = 4;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CALC  = 2'd2,
    ST_APPLY = 2'd3
  } state_e;

  // Saturate a signed candidate position into [0, hi].
  function automatic logic [11:0] clamp_pos(input logic signed [12:0] v, input int hi);
    if (v < 0)       return 12'd0;
    else if (v > hi) return 12'(hi);
    else             return v[11:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tank_motion_ctl_shaper.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jstk_axis_shaper : 10-bit joystick code -> signed per-frame step and |delta|
// Rev 1.0
// ----------------------------------------------------------------------------
module jstk_axis_shaper
  import tank_pkg::*;
#(
  parameter bit INVERT = 1'b0
) (
  input  logic        [9:0]  code_i,
  output logic signed [2:0]  step_o,
  output logic        [10:0] mag_o
);

  logic signed [10:0] delta;
  logic        [2:0]  speed;

  always_comb begin
    delta = {1'b0, code_i} - 11'(CENTER);
    mag_o = delta[10] ? 11'(-delta) : 11'(delta);
    if (mag_o <= 11'(DEADZONE))         speed = 3'd0;
    else if (mag_o < 11'(FAST_THRESH))  speed = 3'(STEP_SLOW);
    else                                speed = 3'(STEP_FAST);
    // Y screen axis grows downward, so a stick pushed up must subtract.
    step_o = (delta[10] ^ INVERT) ? -$signed(speed) : $signed(speed);
  end

endmodule
`default_nettype wire

// File: rtl/tank_motion_ctl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tank_motion_ctl : joystick CDC/filter, per-frame motion FSM, clamped position
// Rev 1.0
// ----------------------------------------------------------------------------
module tank_motion_ctl
  import tank_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_i,
  input  logic        enable_i,
  input  logic [9:0]  jstk_x_i,
  input  logic [9:0]  jstk_y_i,
  output logic [11:0] xpos_o,
  output logic [11:0] ypos_o,
  output logic [1:0]  dir_o,
  output logic        moving_o,
  output logic        frame_update_o
);

  logic [19:0]        sync1_q, sync2_q, prev_q;
  logic [2:0]         stab_cnt_q;
  logic [9:0]         acc_x_q, acc_y_q;
  logic               vsync_q, tick;
  state_e             state_q, state_d;
  logic               load_steps, do_apply;
  logic signed [2:0]  stepx_w, stepy_w, stepx_q, stepy_q;
  logic [10:0]        magx_w, magy_w;
  logic               xwins_q;
  logic [11:0]        xpos_q, ypos_q;
  logic [1:0]         dir_q;
  logic               moving_q, frame_update_q;
  logic signed [12:0] nx, ny;

  jstk_axis_shaper #(.INVERT(1'b0)) u_shape_x (.code_i(acc_x_q), .step_o(stepx_w), .mag_o(magx_w));
  jstk_axis_shaper #(.INVERT(1'b1)) u_shape_y (.code_i(acc_y_q), .step_o(stepy_w), .mag_o(magy_w));

  assign tick = vsync_i & ~vsync_q;

  // A word is accepted only after it has matched its predecessor repeatedly,
  // so a half-updated multi-bit sample can never reach the shapers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= {10'(CENTER), 10'(CENTER)};
      sync2_q    <= {10'(CENTER), 10'(CENTER)};
      prev_q     <= {10'(CENTER), 10'(CENTER)};
      stab_cnt_q <= 3'd0;
      acc_x_q    <= 10'(CENTER);
      acc_y_q    <= 10'(CENTER);
      vsync_q    <= 1'b0;
    end else begin
      sync1_q <= {jstk_x_i, jstk_y_i};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      vsync_q <= vsync_i;
      if (sync2_q != prev_q)
        stab_cnt_q <= 3'd0;
      else if (stab_cnt_q != 3'(STABLE_CYC - 1))
        stab_cnt_q <= stab_cnt_q + 3'd1;
      else
        {acc_x_q, acc_y_q} <= prev_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_steps = 1'b0;
    do_apply   = 1'b0;
    case (state_q)
      ST_IDLE:  if (enable_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!enable_i) state_d = ST_IDLE;
        else if (tick) begin
          state_d    = ST_CALC;
          load_steps = 1'b1;
        end
      end
      ST_CALC: begin
        if (!enable_i) state_d = ST_IDLE;
        else begin
          state_d  = ST_APPLY;
          do_apply = 1'b1;
        end
      end
      ST_APPLY: state_d = enable_i ? ST_WAIT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign nx = signed'({1'b0, xpos_q}) + 13'(stepx_q);
  assign ny = signed'({1'b0, ypos_q}) + 13'(stepy_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      stepx_q        <= 3'sd0;
      stepy_q        <= 3'sd0;
      xwins_q        <= 1'b1;
      xpos_q         <= 12'(X_INIT);
      ypos_q         <= 12'(Y_INIT);
      dir_q          <= DIR_UP;
      moving_q       <= 1'b0;
      frame_update_q <= 1'b0;
    end else begin
      frame_update_q <= 1'b0;
      if (load_steps) begin
        stepx_q <= stepx_w;
        stepy_q <= stepy_w;
        xwins_q <= (magx_w >= magy_w);
      end
      if (state_q == ST_IDLE || !enable_i) begin
        xpos_q   <= 12'(X_INIT);
        ypos_q   <= 12'(Y_INIT);
        dir_q    <= DIR_UP;
        moving_q <= 1'b0;
      end else if (do_apply) begin
        xpos_q         <= clamp_pos(nx, X_MAX);
        ypos_q         <= clamp_pos(ny, Y_MAX);
        moving_q       <= (stepx_q != 3'sd0) || (stepy_q != 3'sd0);
        frame_update_q <= 1'b1;
        if (xwins_q) begin
          if (stepx_q != 3'sd0) dir_q <= stepx_q[2] ? DIR_LEFT : DIR_RIGHT;
        end else begin
          if (stepy_q != 3'sd0) dir_q <= stepy_q[2] ? DIR_UP : DIR_DOWN;
        end
      end
    end
  end

  assign xpos_o         = xpos_q;
  assign ypos_o         = ypos_q;
  assign dir_o          = dir_q;
  assign moving_o       = moving_q;
  assign frame_update_o = frame_update_q;

endmodule
`default_nettype wire

// File: tb/tb_tank_motion_ctl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tank_motion_ctl : directed + random frames against a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_tank_motion_ctl;

  logic        clk = 1'b0;
  logic        rst, vsync_i, enable_i;
  logic [9:0]  jstk_x_i, jstk_y_i;
  logic [11:0] xpos_o, ypos_o;
  logic [1:0]  dir_o;
  logic        moving_o, frame_update_o;

  tank_motion_ctl dut (
    .clk(clk), .rst(rst), .vsync_i(vsync_i), .enable_i(enable_i),
    .jstk_x_i(jstk_x_i), .jstk_y_i(jstk_y_i),
    .xpos_o(xpos_o), .ypos_o(ypos_o), .dir_o(dir_o),
    .moving_o(moving_o), .frame_update_o(frame_update_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_x = 480, m_y = 352, m_dir = 0, m_mov = 0;
  int acc_x = 512, acc_y = 512;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int axis_step(input int code, input bit inv);
    int d, m, s;
    d = code - 512;
    m = (d < 0) ? -d : d;
    s = (m <= 64) ? 0 : (m < 320) ? 1 : 3;
    if (d < 0) s = -s;
    if (inv) s = -s;
    return s;
  endfunction

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  task automatic model_frame();
    int sx, sy, mx, my;
    sx = axis_step(acc_x, 1'b0);
    sy = axis_step(acc_y, 1'b1);
    mx = (acc_x > 512) ? acc_x - 512 : 512 - acc_x;
    my = (acc_y > 512) ? acc_y - 512 : 512 - acc_y;
    m_mov = (sx != 0 || sy != 0) ? 1 : 0;
    if (mx >= my) begin
      if (sx != 0) m_dir = (sx > 0) ? 1 : 3;
    end else begin
      if (sy != 0) m_dir = (sy < 0) ? 0 : 2;
    end
    m_x = clampi(m_x + sx, 960);
    m_y = clampi(m_y + sy, 704);
  endtask

  task automatic model_init();
    m_x = 480; m_y = 352; m_dir = 0; m_mov = 0;
  endtask

  task automatic set_stick(input int x, input int y);
    @(negedge clk);
    jstk_x_i = 10'(x);
    jstk_y_i = 10'(y);
    repeat (16) @(negedge clk);
    acc_x = x;
    acc_y = y;
  endtask

  task automatic do_frame();
    @(negedge clk);
    vsync_i = 1'b1;
    @(posedge clk); #1;
    check("fu_early", frame_update_o, 0);
    @(posedge clk); #1;
    model_frame();
    check("fu_pulse", frame_update_o, 1);
    check("xpos", xpos_o, m_x);
    check("ypos", ypos_o, m_y);
    check("dir", dir_o, m_dir);
    check("moving", moving_o, m_mov);
    @(posedge clk); #1;
    check("fu_single", frame_update_o, 0);
    @(negedge clk);
    vsync_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int x0, pulses;
    rst = 1'b1; vsync_i = 1'b0; enable_i = 1'b1;
    jstk_x_i = 10'd512; jstk_y_i = 10'd512;
    repeat (2) @(posedge clk); #1;
    check("rst_xpos", xpos_o, 480);
    check("rst_ypos", ypos_o, 352);
    check("rst_dir", dir_o, 0);
    check("rst_moving", moving_o, 0);
    check("rst_fu", frame_update_o, 0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);

    // Centered stick: pulses but no motion.
    repeat (3) do_frame();

    set_stick(900, 512);
    repeat (10) do_frame();
    check("fast_right_x", xpos_o, 510);
    check("fast_right_dir", dir_o, 1);
    set_stick(600, 512);
    do_frame();
    check("slow_right_x", xpos_o, 511);

    set_stick(0, 512);
    repeat (200) do_frame();
    check("left_wall_x", xpos_o, 0);
    set_stick(512, 1023);
    repeat (130) do_frame();
    check("top_wall_y", ypos_o, 0);
    check("top_wall_dir", dir_o, 0);

    // Move away from the walls, then deadzone hold and diagonal tie-break.
    set_stick(900, 0);
    repeat (40) do_frame();
    set_stick(560, 520);
    x0 = m_x;
    do_frame();
    check("dz_x_held", xpos_o, x0);
    check("dz_dir_held", dir_o, 2);
    set_stick(0, 1023);
    do_frame();
    check("diag_x", xpos_o, x0 - 3);
    check("diag_dir", dir_o, 3);

    repeat (40) begin
      set_stick($urandom_range(0, 1023), $urandom_range(0, 1023));
      do_frame();
    end

    // Torn/unstable input must never be accepted.
    set_stick(512, 512);
    x0 = m_x;
    fork
      begin
        repeat (8) begin
          jstk_x_i = 10'd100; repeat (2) @(negedge clk);
          jstk_x_i = 10'd900; repeat (2) @(negedge clk);
        end
        jstk_x_i = 10'd512;
      end
      begin
        repeat (6) @(negedge clk);
        do_frame();
      end
    join
    check("toggle_x", xpos_o, x0);
    repeat (16) @(negedge clk);

    // Reset while in CALC discards the frame.
    set_stick(900, 512);
    @(negedge clk); vsync_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1; vsync_i = 1'b0;
    @(posedge clk); #1;
    model_init();
    acc_x = 512; acc_y = 512;
    check("midrst_x", xpos_o, 480);
    check("midrst_y", ypos_o, 352);
    check("midrst_fu", frame_update_o, 0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (frame_update_o) pulses++;
    end
    check("midrst_nopulse", pulses, 0);
    set_stick(900, 512);
    do_frame();

    // Disable: snap home, no pulses while low.
    @(negedge clk); enable_i = 1'b0;
    @(posedge clk); #1;
    model_init();
    check("dis_x", xpos_o, 480);
    check("dis_y", ypos_o, 352);
    pulses = 0;
    @(negedge clk); vsync_i = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (frame_update_o) pulses++;
    end
    @(negedge clk); vsync_i = 1'b0;
    check("dis_nopulse", pulses, 0);
    check("dis_x_hold", xpos_o, 480);
    enable_i = 1'b1;
    repeat (3) @(negedge clk);
    do_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
